// File: rtl/sgpr_busy_table_mw.sv
// sgpr_busy_table_mw
//   Multi-word scalar-register scoreboard for the issue stage. Issue marks a
//   contiguous run of up to MAX_WORDS SGPRs busy, NUM_CLR_PORTS retire ports
//   clear runs independently, and a registered check port reports hazards.
//   Runs that pass the top index wrap modulo NUM_REGS.
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   flush           clear the whole table (beats set and clear)
//   set_addr/mask   base SGPR and word mask of the run to mark busy
//   clr_addr/mask   per-port base/mask, port p at [p*ADDR_W +: ADDR_W] / [p*MAX_WORDS +: MAX_WORDS]
//   chk_addr/mask   hazard query; result chk_valid/chk_busy one cycle later
//   busy_vector     registered table state
//   busy_count      registered number of busy SGPRs
//   err_dbl_set     1-cycle pulse: set hit an SGPR that stays busy
//   err_clr_idle    1-cycle pulse: clear hit an idle SGPR
module sgpr_busy_table_mw #(
  parameter int NUM_REGS      = 512,
  parameter int ADDR_W        = 9,
  parameter int MAX_WORDS     = 4,
  parameter int NUM_CLR_PORTS = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [ADDR_W-1:0]                  set_addr,
  input  logic [MAX_WORDS-1:0]               set_mask,
  input  logic [NUM_CLR_PORTS*ADDR_W-1:0]    clr_addr,
  input  logic [NUM_CLR_PORTS*MAX_WORDS-1:0] clr_mask,
  input  logic [ADDR_W-1:0]                  chk_addr,
  input  logic [MAX_WORDS-1:0]               chk_mask,
  output logic                               chk_valid,
  output logic                               chk_busy,
  output logic [NUM_REGS-1:0]                busy_vector,
  output logic [ADDR_W:0]                    busy_count,
  output logic                               err_dbl_set,
  output logic                               err_clr_idle
);

  // mask << addr into a widened vector; bits past the top fold back to the
  // bottom. MAX_WORDS <= NUM_REGS, so one fold is enough.
  function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_W-1:0]    a,
                                                 input logic [MAX_WORDS-1:0] m);
    logic [NUM_REGS+MAX_WORDS-1:0] ext;
    logic [NUM_REGS-1:0]           res;
    ext = {{NUM_REGS{1'b0}}, m} << a;
    res = ext[NUM_REGS-1:0];
    for (int unsigned i = 0; i < MAX_WORDS; i++) begin
      res[i] = res[i] | ext[NUM_REGS+i];
    end
    return res;
  endfunction

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] set_dec, clr_all, chk_dec;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                chk_valid_q, chk_valid_d;
  logic                chk_busy_q, chk_busy_d;
  logic                dbl_q, dbl_d;
  logic                idle_q, idle_d;

  always_comb begin
    set_dec = decode(set_addr, set_mask);
    chk_dec = decode(chk_addr, chk_mask);
    clr_all = '0;
    for (int unsigned p = 0; p < NUM_CLR_PORTS; p++) begin
      clr_all = clr_all | decode(clr_addr[p*ADDR_W +: ADDR_W],
                                 clr_mask[p*MAX_WORDS +: MAX_WORDS]);
    end

    busy_d = flush ? '0 : ((busy_q & ~clr_all) | set_dec);

    cnt_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end

    // Query sees the post-update state, so same-cycle set/clear are honoured.
    chk_valid_d = |chk_mask;
    chk_busy_d  = |(chk_dec & busy_d);

    dbl_d  = !flush && |(set_dec & busy_q & ~clr_all);
    idle_d = !flush && |(clr_all & ~busy_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q      <= '0;
      cnt_q       <= '0;
      chk_valid_q <= 1'b0;
      chk_busy_q  <= 1'b0;
      dbl_q       <= 1'b0;
      idle_q      <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      chk_valid_q <= chk_valid_d;
      chk_busy_q  <= chk_busy_d;
      dbl_q       <= dbl_d;
      idle_q      <= idle_d;
    end
  end

  assign busy_vector  = busy_q;
  assign busy_count   = cnt_q;
  assign chk_valid    = chk_valid_q;
  assign chk_busy     = chk_busy_q;
  assign err_dbl_set  = dbl_q;
  assign err_clr_idle = idle_q;

endmodule
